// File: rtl/simon_block_feeder.sv
// simon_block_feeder: streaming front/back-end for a pipelined SIMON32/64 core.
// Buffers {key, plaintext} pairs in an input FIFO and issues them to the core as
// one-cycle load pulses. A tag pipeline tracks every block in flight, and the
// core's ciphertext is captured into an output FIFO. Issue is credit-gated so
// that captured ciphertext can never overflow the output FIFO.
// Optional feature: define SIMON_FEEDER_STATS_EN to add the blocks_done counter.
module simon_block_feeder #(
  parameter int unsigned IN_DEPTH     = 4,
  parameter int unsigned OUT_DEPTH    = 4,
  parameter int unsigned CORE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_plaintext,
  input  logic [63:0] in_key,
  output logic        core_load,
  output logic [31:0] core_plaintext,
  output logic [63:0] core_key,
  input  logic [31:0] core_ciphertext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ciphertext,
`ifdef SIMON_FEEDER_STATS_EN
  output logic [15:0] blocks_done,
`endif
  output logic        busy
);

  localparam int unsigned InAw  = $clog2(IN_DEPTH);
  localparam int unsigned OutAw = $clog2(OUT_DEPTH);
  localparam int unsigned TagW  = CORE_LATENCY + 1;
  localparam logic [InAw:0] InFull = (InAw + 1)'(IN_DEPTH);

  logic [95:0]      in_mem_q [IN_DEPTH];
  logic [InAw-1:0]  in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [InAw:0]    in_count_q, in_count_d;
  logic             in_ready_q, in_ready_d;

  logic             core_load_q, core_load_d;
  logic [31:0]      core_pt_q, core_pt_d;
  logic [63:0]      core_key_q, core_key_d;
  logic [TagW-1:0]  tag_q, tag_d;

  logic [31:0]      out_mem_q [OUT_DEPTH];
  logic [OutAw-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [OutAw:0]   out_count_q, out_count_d;

`ifdef SIMON_FEEDER_STATS_EN
  logic [15:0]      blocks_done_q, blocks_done_d;
`endif

  logic [31:0] inflight;
  logic        push, issue, capture, pop;

  // Blocks in flight: the pending load pulse plus every set tag.
  always_comb begin
    inflight = 32'(core_load_q);
    for (int i = 0; i < TagW; i++) begin
      inflight = inflight + 32'(tag_q[i]);
    end
  end

  // Credit check ignores a same-cycle pop, so it can only under-issue.
  assign push    = in_valid & in_ready_q;
  assign issue   = (in_count_q != '0) && ((32'(out_count_q) + inflight) < OUT_DEPTH);
  assign capture = tag_q[TagW-1];
  assign pop     = out_valid & out_ready;

  // Next-state for pointers, counters, issue registers and the tag pipeline.
  always_comb begin
    in_wptr_d   = in_wptr_q;
    in_rptr_d   = in_rptr_q;
    in_count_d  = in_count_q;
    out_wptr_d  = out_wptr_q;
    out_rptr_d  = out_rptr_q;
    out_count_d = out_count_q;
    core_pt_d   = core_pt_q;
    core_key_d  = core_key_q;
    core_load_d = issue;
    tag_d       = {tag_q[TagW-2:0], core_load_q};

    if (push) in_wptr_d = in_wptr_q + InAw'(1);
    if (issue) begin
      in_rptr_d  = in_rptr_q + InAw'(1);
      core_pt_d  = in_mem_q[in_rptr_q][31:0];
      core_key_d = in_mem_q[in_rptr_q][95:32];
    end
    if (push && !issue)      in_count_d = in_count_q + (InAw + 1)'(1);
    else if (!push && issue) in_count_d = in_count_q - (InAw + 1)'(1);
    // Registered so in_ready never depends combinationally on issue.
    in_ready_d = (in_count_d != InFull);

    if (capture) out_wptr_d = out_wptr_q + OutAw'(1);
    if (pop)     out_rptr_d = out_rptr_q + OutAw'(1);
    if (capture && !pop)      out_count_d = out_count_q + (OutAw + 1)'(1);
    else if (!capture && pop) out_count_d = out_count_q - (OutAw + 1)'(1);
  end

`ifdef SIMON_FEEDER_STATS_EN
  // Output handshake counter, wraps naturally at 16 bits.
  always_comb begin
    blocks_done_d = blocks_done_q;
    if (pop) blocks_done_d = blocks_done_q + 16'd1;
  end
`endif

  // State registers; reset discards every buffered and in-flight block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wptr_q   <= '0;
      in_rptr_q   <= '0;
      in_count_q  <= '0;
      in_ready_q  <= 1'b0;
      core_load_q <= 1'b0;
      core_pt_q   <= '0;
      core_key_q  <= '0;
      tag_q       <= '0;
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_count_q <= '0;
`ifdef SIMON_FEEDER_STATS_EN
      blocks_done_q <= '0;
`endif
    end else begin
      in_wptr_q   <= in_wptr_d;
      in_rptr_q   <= in_rptr_d;
      in_count_q  <= in_count_d;
      in_ready_q  <= in_ready_d;
      core_load_q <= core_load_d;
      core_pt_q   <= core_pt_d;
      core_key_q  <= core_key_d;
      tag_q       <= tag_d;
      out_wptr_q  <= out_wptr_d;
      out_rptr_q  <= out_rptr_d;
      out_count_q <= out_count_d;
`ifdef SIMON_FEEDER_STATS_EN
      blocks_done_q <= blocks_done_d;
`endif
    end
  end

  // FIFO storage; output entries are cleared so an empty FIFO reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IN_DEPTH; i++) in_mem_q[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
    end else begin
      if (push)    in_mem_q[in_wptr_q] <= {in_key, in_plaintext};
      if (capture) out_mem_q[out_wptr_q] <= core_ciphertext;
    end
  end

  assign in_ready       = in_ready_q;
  assign core_load      = core_load_q;
  assign core_plaintext = core_pt_q;
  assign core_key       = core_key_q;
  assign out_valid      = (out_count_q != '0);
  assign out_ciphertext = out_mem_q[out_rptr_q];
  assign busy           = (in_count_q != '0) || (inflight != 32'd0) || (out_count_q != '0);
`ifdef SIMON_FEEDER_STATS_EN
  assign blocks_done    = blocks_done_q;
`endif

endmodule

// File: tb/tb_simon_block_feeder.sv
// Self-checking bench for simon_block_feeder with a behavioural SIMON32/64 core.
// Build with SIMON_FEEDER_STATS_EN defined to also cover the blocks_done counter.
module tb_simon_block_feeder;
  localparam int unsigned IN_DEPTH  = 4;
  localparam int unsigned OUT_DEPTH = 8;
  localparam int unsigned CL        = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, core_load, out_valid, out_ready, busy;
  logic [31:0] in_plaintext, core_plaintext, core_ciphertext, out_ciphertext;
  logic [63:0] in_key, core_key;
`ifdef SIMON_FEEDER_STATS_EN
  logic [15:0] blocks_done;
`endif

  simon_block_feeder #(
    .IN_DEPTH    (IN_DEPTH),
    .OUT_DEPTH   (OUT_DEPTH),
    .CORE_LATENCY(CL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_plaintext   (in_plaintext),
    .in_key         (in_key),
    .core_load      (core_load),
    .core_plaintext (core_plaintext),
    .core_key       (core_key),
    .core_ciphertext(core_ciphertext),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ciphertext (out_ciphertext),
`ifdef SIMON_FEEDER_STATS_EN
    .blocks_done    (blocks_done),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Reference SIMON32/64 encryption.
  function automatic logic [31:0] simon(input logic [31:0] pt, input logic [63:0] key);
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int i = 4; i < 32; i++) begin
      t = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
      t = t ^ {t[0], t[15:1]};
      k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]}) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Core model: output valid for one cycle, CL edges after the load-sampling edge.
  logic [CL:0] cv = '0;
  logic [31:0] cct [CL+1];
  always @(posedge clk) begin
    cv     <= {cv[CL-1:0], core_load};
    cct[0] <= simon(core_plaintext, core_key);
    for (int i = 1; i <= CL; i++) cct[i] <= cct[i-1];
  end
  assign core_ciphertext = cv[CL] ? cct[CL] : 32'h0BAD_F00D;

  int n_vec = 0;
  int n_bad = 0;
  int pops = 0;
  int loads = 0;
  int run = 0;
  int max_run = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted pair must come out, in order, as its ciphertext.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pops = 0;
      run  = 0;
    end else begin
      if (core_load) begin
        loads++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(simon(in_plaintext, in_key));
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got %h, expected no output", out_ciphertext);
        end else begin
          chk("ciphertext_order", 128'(out_ciphertext), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic push(input logic [63:0] k, input logic [31:0] p);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_key = k;
    in_plaintext = p;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("push_timeout_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       in_valid;
    logic       out_ready;
    logic [3:0] exp_flags;  // {in_ready, core_load, out_valid, busy}
  } row_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t rows [8];
    int p0, l0;
    rows[0] = '{1'b1, 1'b0, 4'b1000};
    rows[1] = '{1'b0, 1'b0, 4'b1001};
    rows[2] = '{1'b0, 1'b0, 4'b1101};
    rows[3] = '{1'b0, 1'b0, 4'b1001};
    rows[4] = '{1'b0, 1'b0, 4'b1001};
    rows[5] = '{1'b0, 1'b0, 4'b1001};
    rows[6] = '{1'b0, 1'b1, 4'b1011};
    rows[7] = '{1'b0, 1'b0, 4'b1000};

    in_valid = 1'b0;
    in_key = '0;
    in_plaintext = '0;
    out_ready = 1'b0;

    // Reset values while rst is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    chk("reset_core_load", 128'(core_load), 128'(0));
    chk("reset_core_plaintext", 128'(core_plaintext), 128'(0));
    chk("reset_core_key", 128'(core_key), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_ciphertext", 128'(out_ciphertext), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single block latency trace.
    in_key = 64'h1918_1110_0908_0100;
    in_plaintext = 32'h6565_6877;
    for (int r = 0; r < 8; r++) begin
      in_valid = rows[r].in_valid;
      out_ready = rows[r].out_ready;
      @(negedge clk);
      chk($sformatf("single_flags_row%0d", r), 128'({in_ready, core_load, out_valid, busy}),
          128'(rows[r].exp_flags));
      if (r == 2) begin
        chk("single_core_plaintext", 128'(core_plaintext), 128'(32'h6565_6877));
        chk("single_core_key", 128'(core_key), 128'(64'h1918_1110_0908_0100));
      end
      if (r == 6) chk("single_ciphertext", 128'(out_ciphertext), 128'(32'hc69b_e9bb));
      @(posedge clk);
      #1;
    end

    // Streaming 20 blocks with out_ready held high.
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      push(64'h1918_1110_0908_0100 + 64'(i), 32'h6565_6877 ^ (32'(i) * 32'h0101_0101));
    end
    wait_idle(200);
    chk("stream_consecutive_loads", 128'(max_run), 128'(20));
    chk("stream_pops", 128'(pops - p0), 128'(20));
    chk("stream_queue_empty", 128'(exp_q.size()), 128'(0));
`ifdef SIMON_FEEDER_STATS_EN
    chk("stats_after_stream", 128'(blocks_done), 128'(pops[15:0]));
`endif

    // Back-pressure: credits bound issue, then the input FIFO fills.
    out_ready = 1'b0;
    p0 = pops;
    l0 = loads;
    for (int i = 0; i < 12; i++) push(64'h0123_4567_89ab_cdef ^ 64'(i), 32'h0000_1000 + 32'(i));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    chk("bp_issue_count", 128'(loads - l0), 128'(OUT_DEPTH));
    chk("bp_core_load_idle", 128'(core_load), 128'(0));
    chk("bp_out_valid", 128'(out_valid), 128'(1));
    chk("bp_no_pops", 128'(pops - p0), 128'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle(200);
    chk("bp_drain_pops", 128'(pops - p0), 128'(12));
    chk("bp_queue_empty", 128'(exp_q.size()), 128'(0));

    // Push into a full-minus-one input FIFO on the same edge as an issue.
    out_ready = 1'b0;
    p0 = pops;
    l0 = loads;
    for (int i = 0; i < 11; i++) push(64'hfeed_0000_0000_0000 + 64'(i), 32'h7777_0000 + 32'(i));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("fm1_in_ready", 128'(in_ready), 128'(1));
    chk("fm1_issue_count", 128'(loads - l0), 128'(OUT_DEPTH));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_key = 64'haaaa_bbbb_cccc_dddd;
    in_plaintext = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_key = 64'h1111_2222_3333_4444;
    in_plaintext = 32'h9abc_def0;
    @(negedge clk);
    chk("fm1_push_issue_in_ready", 128'(in_ready), 128'(1));
    chk("fm1_push_issue_core_load", 128'(core_load), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fm1_full_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle(200);
    chk("fm1_drain_pops", 128'(pops - p0), 128'(13));
    chk("fm1_queue_empty", 128'(exp_q.size()), 128'(0));

    // Reset with three blocks in flight.
    for (int i = 0; i < 3; i++) push(64'hdead_0000_0000_0000 + 64'(i), 32'h5555_0000 + 32'(i));
    @(posedge clk);
    #1;
    chk("mid_core_load_before_reset", 128'(core_load), 128'(1));
    #1;
    rst = 1'b0;
    #1;
    chk("mid_reset_in_ready", 128'(in_ready), 128'(0));
    chk("mid_reset_core_load", 128'(core_load), 128'(0));
    chk("mid_reset_core_plaintext", 128'(core_plaintext), 128'(0));
    chk("mid_reset_core_key", 128'(core_key), 128'(0));
    chk("mid_reset_out_valid", 128'(out_valid), 128'(0));
    chk("mid_reset_out_ciphertext", 128'(out_ciphertext), 128'(0));
    chk("mid_reset_busy", 128'(busy), 128'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", 128'(in_ready), 128'(1));
    p0 = pops;
    push(64'h1918_1110_0908_0100, 32'h6565_6877);
    wait_idle(200);
    chk("post_reset_pops", 128'(pops - p0), 128'(1));
    chk("post_reset_queue_empty", 128'(exp_q.size()), 128'(0));

`ifdef SIMON_FEEDER_STATS_EN
    chk("stats_after_reset", 128'(blocks_done), 128'(pops[15:0]));
    force dut.blocks_done_q = 16'hffff;
    #1;
    release dut.blocks_done_q;
    chk("stats_preload", 128'(blocks_done), 128'(16'hffff));
    push(64'h0, 32'h0);
    wait_idle(200);
    chk("stats_wrap", 128'(blocks_done), 128'(16'h0000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
